ps2_ascii_fifo: RTL
===================

Name: ps2_ascii_fifo

Overview:
Successor to the single-character keyboard LED decoder. It consumes the KeyboardDecoder outputs and turns each key make event into an ASCII character. It tracks Caps Lock as an internal toggle and Shift as a live modifier. Characters queue in a parametrised show-ahead FIFO, so a downstream consumer (LED/7-seg/text display logic) can drain typed text at its own rate with a pop handshake.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of two, minimum 2
AW, 3, address width; must equal log2(DEPTH)
CAPS_INIT, 0, Caps Lock state loaded at reset (0 = lowercase)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
key_down  input  512  per-scancode held flags from KeyboardDecoder
last_change  input  9  scancode of most recent make/break; bit 8 = E0-extended
key_valid  input  1  one-clk pulse from KeyboardDecoder per make or break event
pop  input  1  consumer accepts char_out this cycle
clear  input  1  synchronous flush of FIFO and overflow flag
char_out  output  7  ASCII at FIFO head; 0 when empty
char_valid  output  1  FIFO not empty
full  output  1  count == DEPTH
count  output  AW+1  entries held, 0..DEPTH
caps_state  output  1  current Caps Lock toggle
overflow  output  1  sticky: a character was dropped because the FIFO was full

Behaviour:
- Reset (async, while high): FIFO pointers and count = 0; char_valid = 0; char_out = 0; full = 0; overflow = 0; caps_state = CAPS_INIT.
- Make event: key_valid == 1 and key_down[last_change] == 1. Break events (key_down bit 0) are ignored.
- Events with last_change[8] == 1 are ignored, including keypad Enter E0 5A.
- Caps Lock (0x58) make: caps_state toggles on the next edge. Nothing is pushed. Auto-repeat makes each toggle again.
- Shift = key_down[0x12] OR key_down[0x59], sampled in the event cycle. Shift make/break itself pushes nothing.
- Letters push ASCII. Uppercase (0x41+i) when caps_state XOR shift, else lowercase (0x61+i). Scancode map, in order A..Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- Digits push '0'..'9' (0x30..0x39) regardless of Shift or Caps. Scancodes for 0..9: 45 16 1E 26 25 2E 36 3D 3E 46.
- Other keys: Space 0x29 -> 0x20; Enter 0x5A -> 0x0D; Backspace 0x66 -> 0x08.
- Any other scancode is ignored.
- Latency: make event at edge N -> entry written at edge N. If the FIFO was empty, char_valid = 1 and char_out holds the character from edge N+1.
- FIFO is show-ahead. char_out and char_valid are driven from registered head/count; no combinational path from pop.
- Pop while char_valid = 1 removes the head at that edge. Pop while empty has no effect and no underflow.
- Push while full (and no pop): character dropped, overflow set to 1. Overflow stays set until clear or reset.
- Push and pop in the same cycle: both occur and count is unchanged. This holds when full, so no drop and no overflow, and when count == 1, where the new character becomes the head next cycle.
- Clear: at the edge, count = 0, pointers = 0, overflow = 0. caps_state is retained. A push coincident with clear is discarded.
- Pointers wrap modulo DEPTH; count saturates logically at DEPTH via the full check.
- Reset asserted mid-stream: all queued characters are lost immediately; caps_state returns to CAPS_INIT.

Test Plan:
- Reset, then make 0x1C with no modifiers -> next cycle char_valid = 1, char_out = 0x61; pop -> char_valid = 0, char_out = 0, count = 0.
- Make 0x58 then make 0x32 -> caps_state = 1, char_out = 0x42. Hold 0x12 and make 0x32 -> second entry 0x62 (Caps XOR Shift).
- Push digits 0x16, 0x1E with Shift held, then 0x29, 0x5A, 0x66 -> FIFO drains 0x31, 0x32, 0x20, 0x0D, 0x08. Break events and E0 5A push nothing.
- With DEPTH = 8, push 9 letters without pop -> full = 1, count = 8, overflow = 1, ninth character absent. Pop all -> first 8 come out in order.
- When full, push and pop in the same cycle -> count stays 8, overflow stays 0, new character appears last after draining. Pointer wrap is exercised over 20+ push/pop cycles with no corruption.
- Clear with 3 entries and overflow = 1 -> count = 0, overflow = 0, caps_state unchanged. Async reset mid-push -> all outputs 0 and caps_state = CAPS_INIT while reset is high.

Source files
------------

// File: rtl/ps2_ascii_fifo.sv
// ps2_ascii_fifo: turns KeyboardDecoder make events into ASCII characters
// and queues them in a show-ahead FIFO. The consumer drains the FIFO with pop.
// Caps Lock is an internal toggle. Shift is a live modifier taken from key_down.
// DEPTH must be a power of two (>= 2) with AW == log2(DEPTH), so that the
// pointers can wrap naturally.
module ps2_ascii_fifo #(
  parameter int   DEPTH     = 8,
  parameter int   AW        = 3,
  parameter logic CAPS_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  input  logic         pop,
  input  logic         clear,
  output logic [6:0]   char_out,
  output logic         char_valid,
  output logic         full,
  output logic [AW:0]  count,
  output logic         caps_state,
  output logic         overflow
);

  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;

  // Decoded scancode: hit = maps to a character; letter = case follows caps/shift
  typedef struct packed {
    logic       hit;
    logic       letter;
    logic [6:0] code;   // lowercase form for letters
  } dec_t;

  // Scancode set 2 -> ASCII. Letters return the lowercase character.
  function automatic dec_t decode(input logic [7:0] sc);
    dec_t d;
    d = '0;
    d.hit    = 1'b1;
    d.letter = 1'b1;
    case (sc)
      8'h1C: d.code = 7'h61; // a
      8'h32: d.code = 7'h62; // b
      8'h21: d.code = 7'h63; // c
      8'h23: d.code = 7'h64; // d
      8'h24: d.code = 7'h65; // e
      8'h2B: d.code = 7'h66; // f
      8'h34: d.code = 7'h67; // g
      8'h33: d.code = 7'h68; // h
      8'h43: d.code = 7'h69; // i
      8'h3B: d.code = 7'h6A; // j
      8'h42: d.code = 7'h6B; // k
      8'h4B: d.code = 7'h6C; // l
      8'h3A: d.code = 7'h6D; // m
      8'h31: d.code = 7'h6E; // n
      8'h44: d.code = 7'h6F; // o
      8'h4D: d.code = 7'h70; // p
      8'h15: d.code = 7'h71; // q
      8'h2D: d.code = 7'h72; // r
      8'h1B: d.code = 7'h73; // s
      8'h2C: d.code = 7'h74; // t
      8'h3C: d.code = 7'h75; // u
      8'h2A: d.code = 7'h76; // v
      8'h1D: d.code = 7'h77; // w
      8'h22: d.code = 7'h78; // x
      8'h35: d.code = 7'h79; // y
      8'h1A: d.code = 7'h7A; // z
      default: begin
        d.letter = 1'b0;
        case (sc)
          8'h45:   d.code = 7'h30;
          8'h16:   d.code = 7'h31;
          8'h1E:   d.code = 7'h32;
          8'h26:   d.code = 7'h33;
          8'h25:   d.code = 7'h34;
          8'h2E:   d.code = 7'h35;
          8'h36:   d.code = 7'h36;
          8'h3D:   d.code = 7'h37;
          8'h3E:   d.code = 7'h38;
          8'h46:   d.code = 7'h39;
          8'h29:   d.code = 7'h20; // space
          8'h5A:   d.code = 7'h0D; // enter
          8'h66:   d.code = 7'h08; // backspace
          default: d.hit  = 1'b0;
        endcase
      end
    endcase
    return d;
  endfunction

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          make_ev, shift, caps_ev, push, pop_ok, wr_en;
  logic [6:0]    push_char;
  dec_t          dec;

  // Event qualification and character generation, all in the event cycle
  always_comb begin
    make_ev   = key_valid & ~last_change[8] & key_down[last_change];
    shift     = key_down[SC_LSHIFT] | key_down[SC_RSHIFT];
    dec       = decode(last_change[7:0]);
    caps_ev   = make_ev & (last_change[7:0] == SC_CAPS);
    push_char = (dec.letter & (caps_state ^ shift)) ? dec.code - 7'h20 : dec.code;
    // a push that coincides with clear is discarded
    push      = make_ev & dec.hit & ~clear;
    pop_ok    = pop & char_valid;
    // when full, a simultaneous pop frees the slot being written
    wr_en     = push & (~full | pop_ok);
  end

  // Caps Lock toggle; survives clear, reloads only on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        caps_state <= CAPS_INIT;
    else if (caps_ev) caps_state <= ~caps_state;
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full & ~pop_ok) overflow <= 1'b1;
    end
  end

  // Storage array; the contents need no reset because reads are gated by count
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_char;
  end

  // Show-ahead head, driven only from registered pointer/count state
  always_comb begin
    char_valid = (count != '0);
    full       = (count == (AW+1)'(DEPTH));
    char_out   = char_valid ? mem[rd_ptr] : 7'h00;
  end

endmodule
